// File: rtl/cs_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// cs_pkg: default parameters and derived-width helpers shared by cs_window_filter and its sub-blocks.
package cs_pkg;

   localparam int CS_DATA_W_DEF = 8;
   localparam int CS_DEPTH_DEF  = 9;
   localparam int CS_SHIFT_DEF  = 3;
   localparam int CS_Y_W_DEF    = 10;

   function automatic int cs_clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return w;
   endfunction

   function automatic int cs_sum_width(input int data_w, input int depth);
      return data_w + cs_clog2(depth);
   endfunction

   // Holds sum + DEPTH*appr with headroom, so stage 2 can never overflow.
   function automatic int cs_acc_width(input int data_w, input int depth);
      return cs_sum_width(data_w, depth) + cs_clog2(depth) + 1;
   endfunction

   function automatic int cs_cnt_width(input int depth);
      return cs_clog2(depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cs_appr_search.sv
`default_nettype none
`timescale 1ns/1ps
// cs_appr_search: combinational search for the largest window entry not exceeding the average.
module cs_appr_search
   import cs_pkg::*;
#(
   parameter int DATA_W = CS_DATA_W_DEF,
   parameter int DEPTH  = CS_DEPTH_DEF
)(
   input  logic [DEPTH*DATA_W-1:0] win_i,
   input  logic [DATA_W-1:0]       avg_i,
   output logic [DATA_W-1:0]       appr_o
);

   logic [DATA_W-1:0] w_entry [DEPTH];
   logic [DATA_W-1:0] w_best;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         assign w_entry[gi] = win_i[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Starting from 0 doubles as the defensive fallback when nothing qualifies.
   always_comb begin
      w_best = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((w_entry[i] <= avg_i) && (w_entry[i] > w_best)) begin
            w_best = w_entry[i];
         end
      end
   end

   assign appr_o = w_best;

endmodule
`default_nettype wire

// File: rtl/cs_window_filter.sv
`default_nettype none
`timescale 1ns/1ps
// cs_window_filter: sliding-window filter, Y = sat((sum + DEPTH*appr) >> SHIFT), 2-cycle pipeline.
// Define CS_ROUND_EN to round the average and the final shift instead of truncating.
module cs_window_filter
   import cs_pkg::*;
#(
   parameter int DATA_W = CS_DATA_W_DEF,
   parameter int DEPTH  = CS_DEPTH_DEF,
   parameter int SHIFT  = CS_SHIFT_DEF,
   parameter int Y_W    = CS_Y_W_DEF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] X,
   output logic              out_valid,
   output logic [Y_W-1:0]    Y
);

   localparam int SUM_W = cs_sum_width(DATA_W, DEPTH);
   localparam int ACC_W = cs_acc_width(DATA_W, DEPTH);
   localparam int CNT_W = cs_cnt_width(DEPTH);
   localparam int AVG_W = SUM_W + 1;
   localparam int RND_W = ACC_W + 1;
   localparam int CMP_W = (ACC_W > Y_W) ? ACC_W : Y_W;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [DEPTH-1:0][DATA_W-1:0] win_q, win_d;
   logic [SUM_W-1:0]             sum_q, sum_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         full_q, full_d;
   logic [SUM_W-1:0]             s1_sum_q;
   logic [DATA_W-1:0]            s1_appr_q;
   logic                         s1_vld_q, s1_vld_d;
   logic                         out_valid_q, out_valid_d;
   logic [Y_W-1:0]               y_q, y_d;

   logic [DEPTH*DATA_W-1:0]      w_win_flat;
   logic [DATA_W-1:0]            w_avg;
   logic [DATA_W-1:0]            w_appr;
   logic [ACC_W-1:0]             w_acc;
   logic [CMP_W-1:0]             w_r;
   logic [Y_W-1:0]               w_y_sat;

   // full_d marks a sample that completes or arrives into a full window.
   always_comb begin
      win_d  = win_q;
      sum_d  = sum_q;
      cnt_d  = cnt_q;
      full_d = 1'b0;
      if (flush) begin
         win_d = '0;
         sum_d = '0;
         cnt_d = '0;
      end else if (in_valid) begin
         win_d  = {win_q[DEPTH-2:0], X};
         sum_d  = sum_q + SUM_W'(X) - SUM_W'(win_q[DEPTH-1]);
         cnt_d  = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
         full_d = (cnt_q >= CNT_FULL - 1'b1);
      end
   end

`ifdef CS_ROUND_EN
   assign w_avg = DATA_W'((AVG_W'(sum_q) + AVG_W'(DEPTH / 2)) / AVG_W'(DEPTH));
`else
   assign w_avg = DATA_W'(sum_q / SUM_W'(DEPTH));
`endif

   assign w_win_flat = win_q;

   cs_appr_search #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_appr_search (
      .win_i  (w_win_flat),
      .avg_i  (w_avg),
      .appr_o (w_appr)
   );

   assign w_acc = ACC_W'(s1_sum_q) + ACC_W'(DEPTH) * ACC_W'(s1_appr_q);

   generate
`ifdef CS_ROUND_EN
      if (SHIFT > 0) begin : g_round
         assign w_r = CMP_W'((RND_W'(w_acc) + (RND_W'(1) << (SHIFT - 1))) >> SHIFT);
      end else begin : g_noshift
         assign w_r = CMP_W'(w_acc);
      end
`else
      begin : g_trunc
         assign w_r = CMP_W'(w_acc >> SHIFT);
      end
`endif
   endgenerate

   assign w_y_sat = (w_r > CMP_W'({Y_W{1'b1}})) ? {Y_W{1'b1}} : Y_W'(w_r);

   // Flush drops in-flight results but leaves Y untouched.
   always_comb begin
      s1_vld_d    = flush ? 1'b0 : full_q;
      out_valid_d = flush ? 1'b0 : s1_vld_q;
      y_d         = (!flush && s1_vld_q) ? w_y_sat : y_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         win_q       <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         full_q      <= 1'b0;
         s1_sum_q    <= '0;
         s1_appr_q   <= '0;
         s1_vld_q    <= 1'b0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
      end else begin
         win_q       <= win_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         full_q      <= full_d;
         s1_sum_q    <= sum_q;
         s1_appr_q   <= w_appr;
         s1_vld_q    <= s1_vld_d;
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
      end
   end

   assign out_valid = out_valid_q;
   assign Y         = y_q;

endmodule
`default_nettype wire
